// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receive model: FSM states, register map
// and reset values, also used by the transmitter's bench.
package max7219_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [3:0] ADDR_NOOP       = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
  localparam logic [3:0] ADDR_DECODE     = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] ADDR_TEST       = 4'hF;

  localparam logic [63:0] RST_DIGITS     = 64'h0;
  localparam logic [7:0]  RST_DECODE     = 8'h00;
  localparam logic [3:0]  RST_INTENSITY  = 4'h0;
  localparam logic [2:0]  RST_SCAN_LIMIT = 3'h0;
  localparam logic [7:0]  RST_SHUTDOWN   = 8'h00;
  localparam logic        RST_TEST       = 1'b0;

  // Idle line levels, used as the synchronizer reset values.
  localparam logic IDLE_STB = 1'b1;
  localparam logic IDLE_CLK = 1'b1;
  localparam logic IDLE_DIN = 1'b0;

endpackage

// File: rtl/spi_max7219_rx_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection against a one-cycle-delayed
// copy of the synchronized level; reset fills the chain with the idle level.
module sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_level,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_LEVEL}};
      prev  <= RESET_LEVEL;
    end else begin
      chain <= {chain[STAGES-2:0], async_level};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_max7219_rx.sv
// Oversampling MAX7219 receiver: shifts 16-bit SPI frames MSB first and
// commits them into a MAX7219-compatible register file on LOAD rising.
module spi_max7219_rx
  import max7219_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_SPI_Stb,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_Din,
  output logic        o_Valid,
  output logic        o_Frame_Error,
  output logic [3:0]  o_Addr,
  output logic [7:0]  o_Data,
  output logic [63:0] o_Digits,
  output logic [7:0]  o_Decode_Mode,
  output logic [3:0]  o_Intensity,
  output logic [2:0]  o_Scan_Limit,
  output logic        o_Shutdown,
  output logic        o_Display_Test
);

  logic stb_level, stb_rise, stb_fall;
  logic clk_level, clk_rise, clk_fall;
  logic din, din_rise, din_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(IDLE_STB)) u_sync_stb (
    .clk(i_Clk), .rst(i_Rst), .async_level(i_SPI_Stb),
    .level(stb_level), .rise(stb_rise), .fall(stb_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(IDLE_CLK)) u_sync_clk (
    .clk(i_Clk), .rst(i_Rst), .async_level(i_SPI_Clk),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(IDLE_DIN)) u_sync_din (
    .clk(i_Clk), .rst(i_Rst), .async_level(i_SPI_Din),
    .level(din), .rise(din_rise), .fall(din_fall)
  );

  state_t                state;
  logic [DATA_WIDTH-1:0] sr, sr_next;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next;
  logic                  frame_full;
  logic [3:0]            frame_addr;
  logic [7:0]            frame_data;
  logic                  shutdown_bit;
  logic                  unused_bits;

  // A Clk edge coinciding with LOAD rising is folded in before the commit decision.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (clk_rise) begin
      sr_next = {sr[DATA_WIDTH-2:0], din};
      if (cnt != CNT_WIDTH'(DATA_WIDTH))
        cnt_next = cnt + 1'b1;
    end
  end

  assign frame_full  = (cnt_next == CNT_WIDTH'(DATA_WIDTH));
  assign frame_addr  = sr_next[11:8];
  assign frame_data  = sr_next[7:0];
  assign o_Shutdown  = ~shutdown_bit;
  assign unused_bits = ^{stb_level, clk_level, clk_fall, din_rise, din_fall,
                         sr_next[DATA_WIDTH-1:12]};

  // The register file is written on the transition into COMMIT, so outputs
  // and the o_Valid pulse appear together during the COMMIT cycle.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state          <= IDLE;
      sr             <= '0;
      cnt            <= '0;
      o_Valid        <= 1'b0;
      o_Frame_Error  <= 1'b0;
      o_Addr         <= ADDR_NOOP;
      o_Data         <= 8'h00;
      o_Digits       <= RST_DIGITS;
      o_Decode_Mode  <= RST_DECODE;
      o_Intensity    <= RST_INTENSITY;
      o_Scan_Limit   <= RST_SCAN_LIMIT;
      shutdown_bit   <= RST_SHUTDOWN[0];
      o_Display_Test <= RST_TEST;
    end else begin
      o_Valid       <= 1'b0;
      o_Frame_Error <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (stb_fall) begin
            state <= SHIFT;
            sr    <= '0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt_next;
          if (stb_rise) begin
            if (frame_full) begin
              state   <= COMMIT;
              o_Valid <= 1'b1;
              o_Addr  <= frame_addr;
              o_Data  <= frame_data;
              case (frame_addr)
                ADDR_DECODE:     o_Decode_Mode  <= frame_data;
                ADDR_INTENSITY:  o_Intensity    <= frame_data[3:0];
                ADDR_SCAN_LIMIT: o_Scan_Limit   <= frame_data[2:0];
                ADDR_SHUTDOWN:   shutdown_bit   <= frame_data[0];
                ADDR_TEST:       o_Display_Test <= frame_data[0];
                default: begin
                  for (int k = 0; k < 8; k++)
                    if (frame_addr == ADDR_DIGIT0 + 4'(k))
                      o_Digits[8*k +: 8] <= frame_data;
                end
              endcase
            end else begin
              state         <= IDLE;
              o_Frame_Error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_max7219_rx.sv
// Self-checking bench: drives SPI frames from the system clock domain and
// compares every cycle against a register-map model fed by a frame queue.
module tb_spi_max7219_rx;
  import max7219_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_SPI_Stb = 1'b1;
  logic        i_SPI_Clk = 1'b1;
  logic        i_SPI_Din = 1'b0;
  logic        o_Valid, o_Frame_Error, o_Shutdown, o_Display_Test;
  logic [3:0]  o_Addr, o_Intensity;
  logic [7:0]  o_Data, o_Decode_Mode;
  logic [63:0] o_Digits;
  logic [2:0]  o_Scan_Limit;

  spi_max7219_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_SPI_Stb(i_SPI_Stb), .i_SPI_Clk(i_SPI_Clk), .i_SPI_Din(i_SPI_Din),
    .o_Valid(o_Valid), .o_Frame_Error(o_Frame_Error),
    .o_Addr(o_Addr), .o_Data(o_Data), .o_Digits(o_Digits),
    .o_Decode_Mode(o_Decode_Mode), .o_Intensity(o_Intensity),
    .o_Scan_Limit(o_Scan_Limit), .o_Shutdown(o_Shutdown),
    .o_Display_Test(o_Display_Test)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0, errors = 0;
  int valid_seen = 0, err_seen = 0, exp_valid = 0, exp_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] frame;
  logic [7:0]  model_reg[16];
  logic [3:0]  model_addr;
  logic [7:0]  model_data;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    foreach (model_reg[i]) model_reg[i] = 8'h00;
    model_addr = 4'h0;
    model_data = 8'h00;
  endfunction

  function automatic logic [63:0] model_digits();
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = model_reg[k+1];
    return d;
  endfunction

  function automatic logic [28:0] model_misc();
    return {model_addr, model_data, model_reg[9], model_reg[10][3:0],
            model_reg[11][2:0], ~model_reg[12][0], model_reg[15][0]};
  endfunction

  // Every cycle: apply any committed frame to the model, then compare outputs.
  initial begin
    model_reset();
    forever begin
      @(posedge i_Clk);
      #1;
      if (i_Rst) begin
        model_reset();
      end else begin
        if (o_Valid) begin
          valid_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: o_Valid=1 required 0");
          end else begin
            frame = exp_q.pop_front();
            model_reg[frame[11:8]] = frame[7:0];
            model_addr = frame[11:8];
            model_data = frame[7:0];
          end
        end
        if (o_Frame_Error) err_seen++;
      end
      checkOutput("digits", o_Digits, model_digits());
      checkOutput("misc", 64'({o_Addr, o_Data, o_Decode_Mode, o_Intensity,
                               o_Scan_Limit, o_Shutdown, o_Display_Test}), 64'(model_misc()));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic shift_bits(input logic [31:0] value, input int nbits, input int cycles);
    for (int i = nbits - 1; i >= 0; i--) begin
      i_SPI_Din = value[i];
      i_SPI_Clk = 1'b0;
      wait_cycles(cycles + 1);
      i_SPI_Clk = 1'b1;
      wait_cycles(cycles + 1);
    end
  endtask

  // One LOAD-framed transfer; each SPI phase lasts cycles+1 system clocks.
  task automatic applyStimulus(input logic [31:0] value, input int nbits, input int cycles);
    i_SPI_Stb = 1'b0;
    wait_cycles(cycles + 1);
    shift_bits(value, nbits, cycles);
    if (nbits >= 16) begin
      exp_q.push_back(value[15:0]);
      exp_valid++;
    end else begin
      exp_err++;
    end
    i_SPI_Stb = 1'b1;
    i_SPI_Din = 1'b0;
    wait_cycles(cycles + 1);
  endtask

  task automatic settle();
    wait_cycles(8);
    checkOutput("valid_count", 64'(valid_seen), 64'(exp_valid));
    checkOutput("error_count", 64'(err_seen), 64'(exp_err));
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wait_cycles(3);
    checkOutput("reset_digits", o_Digits, 64'h0);
    checkOutput("reset_misc", 64'({o_Valid, o_Frame_Error, o_Addr, o_Data, o_Decode_Mode,
                                   o_Intensity, o_Scan_Limit, o_Shutdown, o_Display_Test}),
                64'({1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 4'h0, 3'h0, 1'b1, 1'b0}));
    i_Rst = 1'b0;
    wait_cycles(4);

    $display("[TB] intensity frame");
    applyStimulus(32'h0A07, 16, 1);
    settle();
    checkOutput("lit_addr", 64'(o_Addr), 64'hA);
    checkOutput("lit_data", 64'(o_Data), 64'h07);
    checkOutput("lit_intensity", 64'(o_Intensity), 64'h7);
    checkOutput("lit_untouched", 64'({o_Digits[15:0], o_Decode_Mode, o_Scan_Limit, o_Shutdown, o_Display_Test}),
                64'({16'h0, 8'h00, 3'h0, 1'b1, 1'b0}));
    checkOutput("lit_valid1", 64'(valid_seen), 64'd1);

    $display("[TB] shutdown and digit frames");
    applyStimulus(32'h0C01, 16, 1);
    applyStimulus(32'h0155, 16, 1);
    applyStimulus(32'h08AA, 16, 1);
    settle();
    checkOutput("lit_shutdown", 64'(o_Shutdown), 64'h0);
    checkOutput("lit_digit0", 64'(o_Digits[7:0]), 64'h55);
    checkOutput("lit_digit7", 64'(o_Digits[63:56]), 64'hAA);
    checkOutput("lit_valid4", 64'(valid_seen), 64'd4);

    $display("[TB] short frame");
    applyStimulus(32'h03FF, 10, 1);
    settle();
    checkOutput("lit_frame_err", 64'(err_seen), 64'd1);
    checkOutput("lit_no_valid", 64'(valid_seen), 64'd4);
    checkOutput("lit_digit0_kept", 64'(o_Digits[7:0]), 64'h55);

    $display("[TB] long frame");
    applyStimulus(32'hF0B05, 20, 1);
    settle();
    checkOutput("lit_scan_limit", 64'(o_Scan_Limit), 64'h5);
    checkOutput("lit_valid5", 64'(valid_seen), 64'd5);

    $display("[TB] reset mid-frame");
    i_SPI_Stb = 1'b0;
    wait_cycles(2);
    shift_bits(32'h09, 8, 1);
    i_Rst = 1'b1;
    i_SPI_Stb = 1'b1;
    i_SPI_Clk = 1'b1;
    i_SPI_Din = 1'b0;
    #1;
    checkOutput("lit_rst_digits", o_Digits, 64'h0);
    checkOutput("lit_rst_misc", 64'({o_Valid, o_Addr, o_Intensity, o_Scan_Limit, o_Shutdown}),
                64'({1'b0, 4'h0, 4'h0, 3'h0, 1'b1}));
    wait_cycles(2);
    i_Rst = 1'b0;
    wait_cycles(4);
    applyStimulus(32'h0933, 16, 1);
    settle();
    checkOutput("lit_decode", 64'(o_Decode_Mode), 64'h33);

    $display("[TB] back-to-back random frames");
    for (int n = 0; n < 200; n++)
      applyStimulus(32'($urandom_range(0, 65535)), 16, (n < 100) ? 0 : 4);
    settle();
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("lit_random_errs", 64'(err_seen), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
